mult_share_ctrl: RTL and testbench

Round-robin controller that shares one combinational 3x4 product unit among NREQ requesters. It selects a requester and drives the selected operands into the shared unit from registers. One cycle later it captures the 7-bit product and returns it with the requester's ID. It sits between the requesting blocks and a single product instance; the product instance stays outside this block.

---
 rtl/mult_share_ctrl.sv | 123 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one external 3x4 product unit among NREQ requesters.
// state | meaning: IDLE wait/arbitrate | EXEC operands driven, product settling | DONE result presented
module mult_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [6:0]        mul_res,
  output logic [6:0]        res,
  output logic [IDW-1:0]    res_id,
  output logic              res_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      mul_a_q, mul_a_d;
  logic [3:0]      mul_b_q, mul_b_d;
  logic [6:0]      res_q, res_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_valid_q, res_valid_d;

  logic [2:0] a_arr [NREQ];
  logic [3:0] b_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k] = a_in[3*k +: 3];
    assign b_arr[k] = b_in[4*k +: 4];
  end

  logic           found;
  logic [IDW-1:0] sel, cand;

  // First set request scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = '0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          mul_a_d    = a_arr[sel];
          mul_b_d    = b_arr[sel];
          gnt_d[sel] = 1'b1;
          id_d       = sel;
          ptr_d      = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d       = mul_res;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: directed requests, queued expectations, negedge monitor.
module tb_mult_share_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  gnt;
  logic [2:0]  mul_a;
  logic [3:0]  mul_b;
  logic [6:0]  mul_res;
  logic [6:0]  res;
  logic [1:0]  res_id;
  logic        res_valid;
  logic        busy;

  mult_share_ctrl #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .res(res), .res_id(res_id), .res_valid(res_valid), .busy(busy)
  );

  // Stand-in for the external shared product unit.
  assign mul_res = {4'b0000, mul_a} * {3'b000, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [3:0] g; logic [2:0] a; logic [3:0] b;} gexp_t;
  typedef struct {logic [6:0] r; logic [1:0] id;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int k, input logic [2:0] a, input logic [3:0] b);
    a_in[3*k +: 3] = a;
    b_in[4*k +: 4] = b;
  endtask

  task automatic push_gnt(input int k, input logic [2:0] a, input logic [3:0] b);
    gexp_t e;
    e.g = 4'b0001 << k;
    e.a = a;
    e.b = b;
    gq.push_back(e);
  endtask

  task automatic push_op(input int k, input logic [2:0] a, input logic [3:0] b, input logic [6:0] r);
    rexp_t e;
    push_gnt(k, a, b);
    e.r  = r;
    e.id = 2'(k);
    rq.push_back(e);
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0000 && n < 20);
    if (gnt == 4'b0000) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a result.
  initial begin
    gexp_t ge;
    rexp_t re;
    while (!done) begin
      @(negedge clk);
      check("gnt_rv_exclusive", {31'd0, (gnt != 4'b0000) && res_valid}, 32'd0);
      check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (gnt != 4'b0000) begin
        if (gq.size() == 0) check("unexpected_gnt", {28'd0, gnt}, 32'd0);
        else begin
          ge = gq.pop_front();
          check("gnt", {28'd0, gnt}, {28'd0, ge.g});
          check("mul_a", {29'd0, mul_a}, {29'd0, ge.a});
          check("mul_b", {28'd0, mul_b}, {28'd0, ge.b});
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) check("unexpected_res_valid", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          check("res", {25'd0, res}, {25'd0, re.r});
          check("res_id", {30'd0, res_id}, {30'd0, re.id});
        end
      end
    end
  end

  initial begin
    int n;
    rst  = 1'b1;
    req  = 4'b0000;
    a_in = '0;
    b_in = '0;
    #2;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mul_a", {29'd0, mul_a}, 32'd0);
    check("rst_mul_b", {28'd0, mul_b}, 32'd0);
    check("rst_res", {25'd0, res}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single request: 5 * 11 = 55 from requester 1.
    set_op(1, 3'd5, 4'd11);
    req = 4'b0010;
    push_op(1, 3'd5, 4'd11, 7'd55);
    wait_gnt(n);
    check("single_latency", n, 32'd1);
    check("single_busy_exec", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    check("single_busy_idle", {31'd0, busy}, 32'd0);

    // Full load from reset: rotation 0,1,2,3,0, three cycles apart.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) set_op(k, 3'(k + 1), 4'(k + 6));
    req = 4'b1111;
    push_op(0, 3'd1, 4'd6, 7'd6);
    push_op(1, 3'd2, 4'd7, 7'd14);
    push_op(2, 3'd3, 4'd8, 7'd24);
    push_op(3, 3'd4, 4'd9, 7'd36);
    push_op(0, 3'd1, 4'd6, 7'd6);
    @(negedge clk);
    rst = 1'b0;
    wait_gnt(n);
    check("full_first_latency", n, 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(n);
      check("full_spacing", n, 32'd3);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Wrap-around: requester 3 alone sends ptr to 0, then 0 wins over 3.
    set_op(3, 3'd6, 4'd5);
    req = 4'b1000;
    push_op(3, 3'd6, 4'd5, 7'd30);
    wait_gnt(n);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    set_op(0, 3'd2, 4'd3);
    set_op(3, 3'd7, 4'd1);
    req = 4'b1001;
    push_op(0, 3'd2, 4'd3, 7'd6);
    push_op(3, 3'd7, 4'd1, 7'd7);
    wait_gnt(n);
    check("wrap_first_latency", n, 32'd1);
    wait_gnt(n);
    check("wrap_spacing", n, 32'd3);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Largest operands: 7 * 15 = 105.
    set_op(2, 3'd7, 4'd15);
    req = 4'b0100;
    push_op(2, 3'd7, 4'd15, 7'd105);
    wait_gnt(n);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset while the grant is high: operation discarded, no result pulse.
    set_op(1, 3'd3, 4'd3);
    req = 4'b0010;
    push_gnt(1, 3'd3, 4'd3);
    wait_gnt(n);
    #2;
    rst = 1'b1;
    #1;
    check("abort_gnt", {28'd0, gnt}, 32'd0);
    check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mul_a", {29'd0, mul_a}, 32'd0);
    set_op(2, 3'd5, 4'd4);
    set_op(3, 3'd1, 4'd1);
    req = 4'b1100;
    repeat (4) @(negedge clk);
    push_op(2, 3'd5, 4'd4, 7'd20);
    rst = 1'b0;
    wait_gnt(n);
    check("post_reset_latency", n, 32'd1);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    check("gnt_queue_empty", gq.size(), 32'd0);
    check("res_queue_empty", rq.size(), 32'd0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
